// File: rtl/keep_len_pkg.sv
// Shared widths and types for the keep-mask packet-length accumulator.
// Defaults match the MoldUDP64 datapath: 8-byte beats, 16-bit lengths.
package keep_len_pkg;

    localparam int DEF_KEEP_W  = 8;
    localparam int DEF_KEEP_LW = $clog2(DEF_KEEP_W) + 1;
    localparam int DEF_LEN_W   = 16;

    typedef logic [DEF_KEEP_W-1:0] keep_t;
    typedef logic [DEF_LEN_W-1:0]  len_t;

    localparam len_t LEN_MAX = '1;

endpackage

// File: rtl/keep_thermo_cnt.sv
// Leading-ones counter for an LSB-aligned byte-keep mask (THERMO_CHK_EN adds is_thermo_o).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of keep_i.
module keep_thermo_cnt
    import keep_len_pkg::*;
#(
    parameter int KEEP_W  = DEF_KEEP_W,
    parameter int KEEP_LW = $clog2(KEEP_W) + 1
) (
    input  logic [KEEP_W-1:0]  keep_i,
    output logic [KEEP_LW-1:0] cnt_o
`ifdef THERMO_CHK_EN
    ,
    output logic               is_thermo_o
`endif
);

    logic run;

    // Count stops at the first zero; any ones above it are ignored.
    always_comb begin
        cnt_o = '0;
        run   = 1'b1;
        for (int i = 0; i < KEEP_W; i++) begin
            run   = run & keep_i[i];
            cnt_o = cnt_o + KEEP_LW'(run);
        end
    end

`ifdef THERMO_CHK_EN
    logic [KEEP_W-1:0] keep_inc;

    // A mask of the form 2^k-1 shares no set bit with itself plus one.
    assign keep_inc    = keep_i + KEEP_W'(1);
    assign is_thermo_o = ~|(keep_i & keep_inc);
`endif

endmodule

// File: rtl/keep_len_acc.sv
// Per-packet byte-length accumulator over thermometer keep masks, saturating (THERMO_CHK_EN adds err_o).
// Latency: result valid 1 cycle after the last beat is accepted.
// Backpressure: ready_o drops only while a result is held with len_ready_i low; accumulator frozen then.
module keep_len_acc
    import keep_len_pkg::*;
#(
    parameter int KEEP_W  = DEF_KEEP_W,
    parameter int KEEP_LW = DEF_KEEP_LW,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              valid_i,
    input  logic [KEEP_W-1:0] keep_i,
    input  logic              last_i,
    output logic              ready_o,
    output logic              len_valid_o,
    output logic [LEN_W-1:0]  len_o,
    input  logic              len_ready_i,
    output logic              ovf_o
`ifdef THERMO_CHK_EN
    ,
    output logic              err_o
`endif
);

    localparam int SUM_W = LEN_W + 1;

    logic [KEEP_LW-1:0] beat_cnt;
    logic [LEN_W-1:0]   acc_q;
    logic               pkt_ovf_q;
    logic [SUM_W-1:0]   sum;
    logic               sum_ovf;
    logic [LEN_W-1:0]   sum_sat;
    logic               beat_acc;

`ifdef THERMO_CHK_EN
    logic               is_thermo;

    keep_thermo_cnt #(
        .KEEP_W  (KEEP_W),
        .KEEP_LW (KEEP_LW)
    ) u_cnt (
        .keep_i      (keep_i),
        .cnt_o       (beat_cnt),
        .is_thermo_o (is_thermo)
    );
`else
    keep_thermo_cnt #(
        .KEEP_W  (KEEP_W),
        .KEEP_LW (KEEP_LW)
    ) u_cnt (
        .keep_i (keep_i),
        .cnt_o  (beat_cnt)
    );
`endif

    assign ready_o  = !len_valid_o || len_ready_i;
    assign beat_acc = valid_i && ready_o;

    // One spare carry bit detects overflow; the sum then pins at all-ones.
    assign sum     = {1'b0, acc_q} + SUM_W'(beat_cnt);
    assign sum_ovf = sum[LEN_W];
    assign sum_sat = sum_ovf ? '1 : sum[LEN_W-1:0];

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            acc_q     <= '0;
            pkt_ovf_q <= 1'b0;
        end else if (beat_acc) begin
            if (last_i) begin
                acc_q     <= '0;
                pkt_ovf_q <= 1'b0;
            end else begin
                acc_q     <= sum_sat;
                pkt_ovf_q <= pkt_ovf_q | sum_ovf;
            end
        end
    end

    // A new result overrides the pop, so back-to-back packets keep len_valid_o high.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            len_valid_o <= 1'b0;
            len_o       <= '0;
            ovf_o       <= 1'b0;
        end else if (beat_acc && last_i) begin
            len_valid_o <= 1'b1;
            len_o       <= sum_sat;
            ovf_o       <= pkt_ovf_q | sum_ovf;
        end else if (len_ready_i) begin
            len_valid_o <= 1'b0;
        end
    end

`ifdef THERMO_CHK_EN
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            err_o <= 1'b0;
        end else begin
            err_o <= beat_acc && !is_thermo;
        end
    end

`ifdef FORMAL
    always_comb assert (beat_cnt <= KEEP_LW'(KEEP_W));
`endif
`endif

endmodule

// File: doc/keep_len_acc.md
Name: keep_len_acc

Overview:
Streaming packet-length accumulator for the MoldUDP64 datapath.
- Each accepted beat carries a thermometer keep mask (LSB-aligned contiguous ones).
- The block counts valid bytes per beat and sums them across a packet.
- On the last beat it presents the total byte length through a ready/valid output.
- It is a parametrised, sequential successor to the per-beat thermometer ones counter: it adds accumulation, backpressure, saturation and optional mask checking.

Parameters:
- KEEP_W, 8: keep mask width, in bytes per beat.
- KEEP_LW, 4: per-beat count width; must equal $clog2(KEEP_W)+1.
- LEN_W, 16: accumulated length width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- nreset  in  1  asynchronous active-low reset.
- valid_i  in  1  input beat valid.
- keep_i  in  KEEP_W  thermometer byte-keep mask.
- last_i  in  1  final beat of the packet.
- ready_o  out  1  input beat accepted when valid_i && ready_o.
- len_valid_o  out  1  length result valid.
- len_o  out  LEN_W  packet byte length.
- len_ready_i  in  1  consumer accepts the result.
- ovf_o  out  1  length saturated; qualified by len_valid_o.

Behaviour:
- Per-beat count = number of consecutive ones starting at keep_i[0].
  - Range 0..KEEP_W; 0x00 gives 0.
  - Bits above the first zero are ignored, so the count is defined for any mask.
- Reset (asynchronous, nreset low): acc_q=0, pkt_ovf_q=0, len_valid_o=0, len_o=0, ovf_o=0.
- ready_o = !len_valid_o || len_ready_i. It is combinational and equals 1 during and after reset.
- Accepted non-last beat:
  - acc_q <= sat(acc_q + cnt).
  - pkt_ovf_q set if the sum exceeds 2^LEN_W-1.
- Accepted last beat at cycle N:
  - len_o <= sat(acc_q + cnt).
  - ovf_o <= pkt_ovf_q | overflow of this add.
  - len_valid_o <= 1 at N+1.
  - acc_q <= 0 and pkt_ovf_q <= 0.
  - Latency is 1 cycle from last-beat acceptance to len_valid_o.
- Saturation: the sum clamps to 2^LEN_W-1 and stays there until the last beat.
- Output handshake:
  - len_valid_o && len_ready_i with no new last accepted: len_valid_o <= 0.
  - len_o and ovf_o hold their values while len_valid_o && !len_ready_i.
- Simultaneous result consumption and new last accepted in the same cycle: the new result is loaded and len_valid_o stays 1. This supports back-to-back single-beat packets at 1 result/cycle.
- Stall: while len_valid_o && !len_ready_i, ready_o=0 and no beat is accepted, including non-last beats. The accumulator is frozen.
- valid_i low: no state change apart from the output handshake.
- Reset mid-packet discards the partial sum. The first beat after reset starts a new packet.
- Single-beat packet (last_i on the first beat) is legal.

Optional Feature:
THERMO_CHK_EN
- With the macro defined:
  - Adds output port err_o (1 bit).
  - An accepted beat whose keep_i is not of the form 2^k-1 pulses err_o high for exactly the cycle after acceptance. Reset value is 0.
  - The count still uses the leading-ones rule.
  - Adds a FORMAL assertion that the per-beat count never exceeds KEEP_W.
- Without the macro: no err_o port and no check logic; counting behaviour is identical.

Decomposition:
- Shared package keep_len_pkg holds:
  - the keep_t and len_t typedefs;
  - a LEN_MAX constant (all ones, LEN_W bits).
- One natural sub-module: keep_thermo_cnt. It is a combinational leading-ones counter, keep_i in, KEEP_LW-bit count out, and includes the is-thermometer flag used by THERMO_CHK_EN.
- The accumulator, saturation and handshake logic stay in the top level.

Test Plan:
All tests use KEEP_W=8, LEN_W=16 unless stated.
1. Beats 0xFF, 0xFF, then 0x07 with last, len_ready_i=1 -> len_valid_o one cycle after the last beat, len_o=19, ovf_o=0.
2. Single beat keep=0x00 with last -> len_o=0, len_valid_o for one cycle.
3. len_ready_i=0; packet A = 0xFF last, then packet B = 0x07 last presented -> ready_o=0 while A is held. Raising len_ready_i takes A (8); B is then accepted and yields 3.
4. len_ready_i=1; consecutive-cycle beats 0x01 last, 0x03 last, 0x0F last -> len_valid_o stays high for 3 cycles with len_o=1, 2, 4.
5. LEN_W=4; beats 0xFF, 0xFF last -> len_o=15, ovf_o=1. Next packet 0x01 last -> len_o=1, ovf_o=0.
6. Beat 0xFF non-last, then nreset pulse, then 0x03 last -> len_o=2, and len_valid_o=0 during reset. With THERMO_CHK_EN, beat 0x0B last -> len_o=2 and a single-cycle err_o pulse.
